// File: rtl/pc_fetch_if.sv
// ============================================================================
//  Module   : pc_fetch_if
//  Brief    : Fetch-stage bus: redirects and hazards in, PC and IF/ID out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_if;
    logic        stall_f;
    logic        flush_d;
    logic        jump;
    logic [31:0] jump_addr;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        halted;

    modport master (
        output stall_f, flush_d, jump, jump_addr, branch_taken, branch_addr, instr_f,
        input  pc_f, instr_d, pc_plus4_d, valid_d, halted
    );

    modport slave (
        input  stall_f, flush_d, jump, jump_addr, branch_taken, branch_addr, instr_f,
        output pc_f, instr_d, pc_plus4_d, valid_d, halted
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_stage.sv
// ============================================================================
//  Module   : pc_fetch_stage
//  Brief    : PC register, IF/ID pipeline register and halt/drain sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
    input  wire logic   clk,
    input  wire logic   reset,
    pc_fetch_if.slave   bus
);

    localparam int               c_cnt_w    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DRAIN_CYCLES - 1);

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        w_pc_nxt;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        r_instr_d;
    logic [31:0]        r_pc_plus4_d;
    logic               r_valid_d;
    logic               r_halted;
    logic               w_run;
    logic               w_squash;
    logic               w_halt_det;
    logic               w_ifid_load;
    logic               w_ifid_nop;
    logic               w_unused_bits;

    assign w_run      = (r_state == c_st_run);
    assign w_squash   = bus.flush_d | bus.jump | bus.branch_taken;
    assign w_pc_plus4 = r_pc + 32'd4;
    // A halt word on a squashed (wrong-path) cycle must not end fetch.
    assign w_halt_det = w_run & ~bus.stall_f & ~w_squash & (bus.instr_f == HALT_WORD);

    assign w_unused_bits = ^{bus.jump_addr[1:0], bus.branch_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_run;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_run: begin
                if (w_halt_det) begin
                    w_state_nxt = c_st_drain;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            c_st_drain: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            c_st_done: w_state_nxt = c_st_done;
            default:   w_state_nxt = c_st_run;
        endcase
    end

    // Drain/done override everything, including stall; otherwise stall wins.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_ifid_load = 1'b0;
        w_ifid_nop  = 1'b0;
        if (!w_run) begin
            w_ifid_nop = 1'b1;
        end else if (!bus.stall_f) begin
            if (bus.jump) begin
                w_pc_nxt = {bus.jump_addr[31:2], 2'b00};
            end else if (bus.branch_taken) begin
                w_pc_nxt = {bus.branch_addr[31:2], 2'b00};
            end else if (!w_halt_det) begin
                w_pc_nxt = w_pc_plus4;
            end
            if (w_squash || w_halt_det) begin
                w_ifid_nop = 1'b1;
            end else begin
                w_ifid_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= {RESET_PC[31:2], 2'b00};
            r_instr_d    <= 32'h0;
            r_pc_plus4_d <= 32'h0;
            r_valid_d    <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_halted <= (w_state_nxt == c_st_done);
            if (w_ifid_nop) begin
                r_instr_d <= 32'h0;
                r_valid_d <= 1'b0;
            end else if (w_ifid_load) begin
                r_instr_d    <= bus.instr_f;
                r_pc_plus4_d <= w_pc_plus4;
                r_valid_d    <= 1'b1;
            end
        end
    end

    assign bus.pc_f       = r_pc;
    assign bus.instr_d    = r_instr_d;
    assign bus.pc_plus4_d = r_pc_plus4_d;
    assign bus.valid_d    = r_valid_d;
    assign bus.halted     = r_halted;

endmodule

`default_nettype wire

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 4, the number of cycles between halt detection and halted assertion.
REQ-003 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, the instruction encoding that ends fetch.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port stall_f, input, 1: hazard stall; holds the PC and the IF/ID register.
REQ-007 Port flush_d, input, 1: squashes the IF/ID register to a NOP.
REQ-008 Port jump, input, 1: jump or jr taken in ID.
REQ-009 Port jump_addr, input, 32: jump target from the ID-stage jump address unit.
REQ-010 Port branch_taken, input, 1: branch resolved taken in ID.
REQ-011 Port branch_addr, input, 32: branch target.
REQ-012 Port instr_f, input, 32: instruction word read combinationally from instruction memory at pc_f.
REQ-013 Port pc_f, output, 32: current fetch address to instruction memory.
REQ-014 Port instr_d, output, 32: IF/ID-registered instruction.
REQ-015 Port pc_plus4_d, output, 32: IF/ID-registered pc_f+4.
REQ-016 Port valid_d, output, 1: instr_d is a real, non-squashed instruction.
REQ-017 Port halted, output, 1: asserted once the drain completes.

Function
REQ-018 Next-PC priority SHALL be: reset, then stall_f (hold), then state not RUN (hold), then jump (jump_addr), then branch_taken (branch_addr), then halt detect (hold), then pc_f+4.
REQ-019 pc_f[1:0] SHALL always be 2'b00; bits [1:0] of redirect targets are discarded.
REQ-020 pc_f+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); the same applies to pc_plus4_d.
REQ-021 When stall_f=1, the IF/ID register (instr_d, pc_plus4_d, valid_d) SHALL hold its value regardless of flush_d, jump or branch_taken.
REQ-022 When stall_f=0 and (flush_d | jump | branch_taken)=1, the IF/ID register SHALL load instr_d=32'h0 and valid_d=0; pc_plus4_d is don't-care.
REQ-023 When stall_f=0, there is no squash, and the state is RUN, the IF/ID register SHALL load instr_f, pc_f+4 and valid_d=1, except as given in REQ-025.
REQ-024 Redirect latency SHALL be one cycle: a redirect sampled at edge N sets pc_f to the target after edge N.
REQ-025 Halt detection SHALL occur when state=RUN, stall_f=0, no squash, and instr_f==HALT_WORD; on that edge:
  - PC holds;
  - IF/ID loads the NOP with valid_d=0;
  - the state moves to DRAIN;
  - the drain counter loads DRAIN_CYCLES-1.
REQ-026 A HALT_WORD fetched in the same cycle as a squash (flush_d, jump or branch_taken) SHALL be ignored as wrong-path.
REQ-027 The state machine SHALL have exactly the states RUN, DRAIN and DONE.
  - RUN -> DRAIN on halt detect.
  - DRAIN: the counter decrements each cycle; DRAIN -> DONE on the edge where the counter equals 0.
  - DONE is absorbing until reset.
REQ-028 In DRAIN and DONE:
  - PC SHALL hold;
  - IF/ID SHALL load the NOP with valid_d=0 every cycle;
  - stall_f, flush_d, jump and branch_taken are ignored.
REQ-029 halted SHALL be 1 exactly when state=DONE, registered, so it asserts DRAIN_CYCLES cycles after the halt-detect edge.
REQ-030 DRAIN_CYCLES=1 SHALL go RUN -> DRAIN -> DONE with a single DRAIN cycle; values below 1 are unsupported.

Reset
REQ-031 On a rising edge with reset=1, regardless of any other input, the block SHALL set:
  - pc_f=RESET_PC, instr_d=32'h0, pc_plus4_d=32'h0;
  - valid_d=0, halted=0;
  - state=RUN, drain counter=0.
REQ-032 Reset asserted during DRAIN or DONE SHALL return the block to RUN at RESET_PC on that edge, with fetch resuming on the next edge.

Verification
REQ-033 Sequential fetch: reset, then 3 cycles of instr_f=32'h2001_0005 -> pc_f=0,4,8,12; instr_d=32'h2001_0005; pc_plus4_d=4,8,12; valid_d=1 from the second edge.
REQ-034 Jump vs branch: at pc_f=0x10, jump=1, jump_addr=0x40 and branch_taken=1, branch_addr=0x80 -> next pc_f=0x40; instr_d=0; valid_d=0.
REQ-035 Stall over flush: at pc_f=0x20 with IF/ID holding (0x8C22_0000, 0x20, valid 1), stall_f=1 and flush_d=1 for 2 cycles -> pc_f stays 0x20; IF/ID unchanged; after release, pc_f=0x24.
REQ-036 Halt drain: HALT_WORD at pc_f=0x30 with DRAIN_CYCLES=4 -> pc_f frozen at 0x30; valid_d=0; halted rises 4 edges after detect; a jump=1 during DRAIN has no effect.
REQ-037 Wrong-path halt and wrap:
  - HALT_WORD with branch_taken=1, branch_addr=0x100 -> no halt; pc_f=0x100.
  - Redirect to 0xFFFF_FFFE -> pc_f=0xFFFF_FFFC, then 0x0000_0000.
REQ-038 Reset in DONE: reset=1 for one edge while halted=1 -> halted=0, pc_f=RESET_PC, valid_d=0; the next edge fetches normally.
